// File: rtl/mem_wr_scheduler_if.sv
// Write-request / RAM-write bus shared between requesters and mem_wr_scheduler.
// master = requester side, slave = scheduler side.
interface mem_wr_scheduler_if #(
  parameter int ADDR_WIDTH = 9,
  parameter int DATA_WIDTH = 64,
  parameter int NB_REQ     = 4,
  parameter int NB_WRAGENT = 2
);
  logic [NB_REQ-1:0]                req_valid;
  logic [NB_REQ-1:0]                req_ready;
  logic [NB_REQ*ADDR_WIDTH-1:0]     req_addr;
  logic [NB_REQ*DATA_WIDTH-1:0]     req_data;
  logic [NB_WRAGENT-1:0]            wren;
  logic [NB_WRAGENT*ADDR_WIDTH-1:0] wraddr;
  logic [NB_WRAGENT*DATA_WIDTH-1:0] wrdata;
  logic                             init_done;

  modport master (
    output req_valid, req_addr, req_data,
    input  req_ready, wren, wraddr, wrdata, init_done
  );

  modport slave (
    input  req_valid, req_addr, req_data,
    output req_ready, wren, wraddr, wrdata, init_done
  );
endinterface

// File: rtl/mem_wr_scheduler.sv
// Round-robin scheduler mapping NB_REQ write requesters onto NB_WRAGENT RAM
// write ports, with same-cycle address de-duplication and optional RAM clear.
module mem_wr_scheduler #(
  parameter int                    ADDR_WIDTH = 9,
  parameter int                    RAM_DEPTH  = 2**ADDR_WIDTH,
  parameter int                    DATA_WIDTH = 64,
  parameter int                    NB_REQ     = 4,
  parameter int                    NB_WRAGENT = 2,
  parameter bit                    INIT_EN    = 1'b1,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
  input logic               aclk,
  input logic               areset,
  mem_wr_scheduler_if.slave bus
);
  localparam int PTR_W = $clog2(NB_REQ);
  localparam int CNT_W = $clog2(RAM_DEPTH + NB_WRAGENT) + 1;
  localparam int GNT_W = $clog2(NB_WRAGENT + 1);

  typedef enum logic {INIT, RUN} state_t;

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [PTR_W-1:0]      rr_ptr_q, rr_ptr_d;
  logic [NB_WRAGENT-1:0] wren_q, wren_d;
  logic [ADDR_WIDTH-1:0] wraddr_q [NB_WRAGENT];
  logic [ADDR_WIDTH-1:0] wraddr_d [NB_WRAGENT];
  logic [DATA_WIDTH-1:0] wrdata_q [NB_WRAGENT];
  logic [DATA_WIDTH-1:0] wrdata_d [NB_WRAGENT];

  logic [ADDR_WIDTH-1:0] req_addr_a [NB_REQ];
  logic [DATA_WIDTH-1:0] req_data_a [NB_REQ];

  logic [NB_REQ-1:0]     grant;
  logic [GNT_W-1:0]      n_grant;
  logic [PTR_W-1:0]      last_idx;
  logic [ADDR_WIDTH-1:0] g_addr [NB_WRAGENT];
  logic [DATA_WIDTH-1:0] g_data [NB_WRAGENT];
  logic [PTR_W:0]        scan_sum;
  logic [PTR_W-1:0]      scan_idx;
  logic                  c_valid;
  logic [ADDR_WIDTH-1:0] c_addr;
  logic [DATA_WIDTH-1:0] c_data;
  logic                  c_conflict;

  for (genvar gi = 0; gi < NB_REQ; gi++) begin : g_req_lane
    assign req_addr_a[gi] = bus.req_addr[gi*ADDR_WIDTH +: ADDR_WIDTH];
    assign req_data_a[gi] = bus.req_data[gi*DATA_WIDTH +: DATA_WIDTH];
  end

  for (genvar gi = 0; gi < NB_WRAGENT; gi++) begin : g_wr_port
    assign bus.wraddr[gi*ADDR_WIDTH +: ADDR_WIDTH] = wraddr_q[gi];
    assign bus.wrdata[gi*DATA_WIDTH +: DATA_WIDTH] = wrdata_q[gi];
  end

  assign bus.wren      = wren_q;
  assign bus.req_ready = grant;
  assign bus.init_done = (state_q == RUN);

  // Greedy scan from rr_ptr: j-th accepted requester lands on write port j.
  always_comb begin
    grant      = '0;
    n_grant    = '0;
    last_idx   = rr_ptr_q;
    scan_sum   = '0;
    scan_idx   = '0;
    c_valid    = 1'b0;
    c_addr     = '0;
    c_data     = '0;
    c_conflict = 1'b0;
    for (int j = 0; j < NB_WRAGENT; j++) begin
      g_addr[j] = '0;
      g_data[j] = '0;
    end
    if (state_q == RUN && !areset) begin
      for (int s = 0; s < NB_REQ; s++) begin
        scan_sum = {1'b0, rr_ptr_q} + (PTR_W+1)'(s);
        if (scan_sum >= (PTR_W+1)'(NB_REQ)) begin
          scan_sum = scan_sum - (PTR_W+1)'(NB_REQ);
        end
        scan_idx = scan_sum[PTR_W-1:0];
        c_valid  = 1'b0;
        c_addr   = '0;
        c_data   = '0;
        for (int i = 0; i < NB_REQ; i++) begin
          if (PTR_W'(i) == scan_idx) begin
            c_valid = bus.req_valid[i];
            c_addr  = req_addr_a[i];
            c_data  = req_data_a[i];
          end
        end
        if (c_valid && n_grant < GNT_W'(NB_WRAGENT)) begin
          c_conflict = 1'b0;
          for (int j = 0; j < NB_WRAGENT; j++) begin
            if (GNT_W'(j) < n_grant && g_addr[j] == c_addr) begin
              c_conflict = 1'b1;
            end
          end
          if (!c_conflict) begin
            for (int j = 0; j < NB_WRAGENT; j++) begin
              if (GNT_W'(j) == n_grant) begin
                g_addr[j] = c_addr;
                g_data[j] = c_data;
              end
            end
            for (int i = 0; i < NB_REQ; i++) begin
              if (PTR_W'(i) == scan_idx) begin
                grant[i] = 1'b1;
              end
            end
            n_grant  = n_grant + GNT_W'(1);
            last_idx = scan_idx;
          end
        end
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rr_ptr_d = rr_ptr_q;
    wren_d   = '0;
    wraddr_d = wraddr_q;
    wrdata_d = wrdata_q;
    case (state_q)
      INIT: begin
        for (int k = 0; k < NB_WRAGENT; k++) begin
          if ((cnt_q + CNT_W'(k)) < CNT_W'(RAM_DEPTH)) begin
            wren_d[k]   = 1'b1;
            wraddr_d[k] = ADDR_WIDTH'(cnt_q + CNT_W'(k));
            wrdata_d[k] = INIT_VALUE;
          end
        end
        cnt_d = cnt_q + CNT_W'(NB_WRAGENT);
        if ((cnt_q + CNT_W'(NB_WRAGENT)) >= CNT_W'(RAM_DEPTH)) begin
          state_d = RUN;
        end
      end
      RUN: begin
        for (int j = 0; j < NB_WRAGENT; j++) begin
          if (GNT_W'(j) < n_grant) begin
            wren_d[j]   = 1'b1;
            wraddr_d[j] = g_addr[j];
            wrdata_d[j] = g_data[j];
          end
        end
        if (n_grant != '0) begin
          rr_ptr_d = (last_idx == PTR_W'(NB_REQ - 1)) ? '0 : last_idx + PTR_W'(1);
        end
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_q  <= INIT_EN ? INIT : RUN;
      cnt_q    <= '0;
      rr_ptr_q <= '0;
      wren_q   <= '0;
      for (int j = 0; j < NB_WRAGENT; j++) begin
        wraddr_q[j] <= '0;
        wrdata_q[j] <= '0;
      end
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rr_ptr_q <= rr_ptr_d;
      wren_q   <= wren_d;
      wraddr_q <= wraddr_d;
      wrdata_q <= wrdata_d;
    end
  end
endmodule

// File: tb/tb_mem_wr_scheduler.sv
// Scoreboard bench for mem_wr_scheduler: a requester/arbiter model predicts
// grants and queues the expected write beat, checked one cycle later.
module tb_mem_wr_scheduler;
  localparam int AW = 9;
  localparam int DW = 64;
  localparam int NR = 4;
  localparam int NW = 2;

  logic aclk = 1'b0;
  logic areset = 1'b1;
  logic areset2 = 1'b1;
  always #5 aclk = ~aclk;

  mem_wr_scheduler_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NB_REQ(NR), .NB_WRAGENT(NW)) bus ();
  mem_wr_scheduler_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NB_REQ(NR), .NB_WRAGENT(NW)) bus2 ();

  mem_wr_scheduler #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NB_REQ(NR), .NB_WRAGENT(NW), .INIT_EN(1'b1)
  ) dut (
    .aclk(aclk), .areset(areset), .bus(bus)
  );

  mem_wr_scheduler #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NB_REQ(NR), .NB_WRAGENT(NW), .INIT_EN(1'b0)
  ) dut2 (
    .aclk(aclk), .areset(areset2), .bus(bus2)
  );

  typedef struct packed {
    logic [NW-1:0]    wren;
    logic [NW*AW-1:0] addr;
    logic [NW*DW-1:0] data;
  } beat_t;

  beat_t sb_q[$];

  int n_cmp = 0;
  int n_err = 0;

  logic          p_valid [NR];
  logic [AW-1:0] p_addr  [NR];
  logic [DW-1:0] p_data  [NR];
  int            m_rr;
  logic [AW-1:0] m_last_addr [NW];
  logic [DW-1:0] m_last_data [NW];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h @%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic apply_inputs();
    for (int i = 0; i < NR; i++) begin
      bus.req_valid[i]            = p_valid[i];
      bus.req_addr[i*AW +: AW]    = p_addr[i];
      bus.req_data[i*DW +: DW]    = p_data[i];
    end
  endtask

  task automatic set_req(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
    p_valid[i] = 1'b1;
    p_addr[i]  = a;
    p_data[i]  = d;
  endtask

  // One RUN cycle: predict grants, check ready, then check the registered beat.
  task automatic step();
    beat_t         b;
    logic [NR-1:0] exp_rdy;
    logic [AW-1:0] ga [NW];
    int            n;
    int            last;
    int            idx;
    bit            hit;
    apply_inputs();
    #1;
    exp_rdy = '0;
    n = 0;
    last = 0;
    for (int j = 0; j < NW; j++) ga[j] = '0;
    for (int s = 0; s < NR; s++) begin
      idx = (m_rr + s) % NR;
      if (p_valid[idx] && n < NW) begin
        hit = 0;
        for (int j = 0; j < n; j++) if (ga[j] == p_addr[idx]) hit = 1;
        if (!hit) begin
          ga[n] = p_addr[idx];
          exp_rdy[idx] = 1'b1;
          m_last_addr[n] = p_addr[idx];
          m_last_data[n] = p_data[idx];
          n++;
          last = idx;
        end
      end
    end
    if (n > 0) m_rr = (last + 1) % NR;
    b.wren = '0;
    for (int j = 0; j < NW; j++) begin
      if (j < n) b.wren[j] = 1'b1;
      b.addr[j*AW +: AW] = m_last_addr[j];
      b.data[j*DW +: DW] = m_last_data[j];
    end
    check("req_ready", 64'(bus.req_ready), 64'(exp_rdy));
    sb_q.push_back(b);
    for (int i = 0; i < NR; i++) if (exp_rdy[i]) p_valid[i] = 1'b0;
    @(posedge aclk);
    #1;
    b = sb_q.pop_front();
    $display("beat: wren=%b addr=%h/%h", bus.wren, bus.wraddr[AW +: AW], bus.wraddr[0 +: AW]);
    check("wren", 64'(bus.wren), 64'(b.wren));
    for (int j = 0; j < NW; j++) begin
      check("wraddr", 64'(bus.wraddr[j*AW +: AW]), 64'(b.addr[j*AW +: AW]));
      check("wrdata", bus.wrdata[j*DW +: DW], b.data[j*DW +: DW]);
    end
  endtask

  // Full INIT sequence: called between edges, returns at posedge+1 after the last batch.
  task automatic init_phase();
    for (int c = 0; c < 256; c++) begin
      check("init_ready", 64'(bus.req_ready), 64'd0);
      @(posedge aclk);
      #1;
      check("init_wren", 64'(bus.wren), 64'd3);
      check("init_addr0", 64'(bus.wraddr[0 +: AW]), 64'(2 * c));
      check("init_addr1", 64'(bus.wraddr[AW +: AW]), 64'(2 * c + 1));
      check("init_data0", bus.wrdata[0 +: DW], 64'd0);
      check("init_data1", bus.wrdata[DW +: DW], 64'd0);
      check("init_done", 64'(bus.init_done), (c == 255) ? 64'd1 : 64'd0);
    end
    $display("init: complete, init_done=%0b", bus.init_done);
    m_rr = 0;
    m_last_addr[0] = 9'd510;
    m_last_addr[1] = 9'd511;
    m_last_data[0] = '0;
    m_last_data[1] = '0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_wren"}, 64'(bus.wren), 64'd0);
    check({tag, "_wraddr"}, 64'(bus.wraddr), 64'd0);
    check({tag, "_wrdata0"}, bus.wrdata[0 +: DW], 64'd0);
    check({tag, "_wrdata1"}, bus.wrdata[DW +: DW], 64'd0);
    check({tag, "_ready"}, 64'(bus.req_ready), 64'd0);
    check({tag, "_init_done"}, 64'(bus.init_done), 64'd0);
  endtask

  initial begin
    int pend;
    for (int i = 0; i < NR; i++) begin
      p_valid[i] = 1'b0;
      p_addr[i]  = '0;
      p_data[i]  = '0;
    end
    apply_inputs();
    bus2.req_valid = 4'b0010;
    bus2.req_addr  = '0;
    bus2.req_data  = '0;
    bus2.req_addr[AW +: AW] = 9'h055;
    bus2.req_data[DW +: DW] = 64'hDEAD_BEEF_0000_0055;

    // Requests raised during reset/INIT are ignored until RUN.
    for (int i = 0; i < NR; i++) set_req(i, AW'(9'h010 + 9'(i)), 64'hD000_0000_0000_0000 | 64'(i));
    apply_inputs();
    repeat (3) @(posedge aclk);
    #1;
    check_reset_outputs("rst");
    areset = 1'b0;
    init_phase();

    // All four valid, distinct addresses: two grant cycles, rr back to 0.
    step();
    step();
    step(); // idle

    // Address conflict on 0x40.
    set_req(0, 9'h040, 64'hAAAA_AAAA_AAAA_AAAA);
    set_req(1, 9'h040, 64'hBBBB_BBBB_BBBB_BBBB);
    set_req(2, 9'h041, 64'hCCCC_CCCC_CCCC_CCCC);
    step();
    step();
    check("conflict_wren", 64'(bus.wren), 64'd1);
    check("conflict_addr", 64'(bus.wraddr[0 +: AW]), 64'h40);
    check("conflict_data", bus.wrdata[0 +: DW], 64'hBBBB_BBBB_BBBB_BBBB);

    // Move rr to 1, then req3 alone for three cycles.
    set_req(0, 9'h0F0, 64'h1);
    step();
    for (int k = 0; k < 3; k++) begin
      set_req(3, AW'(9'h0A0 + 9'(k)), 64'h3300 + 64'(k));
      step();
      check("single_wren", 64'(bus.wren), 64'd1);
    end

    // Random traffic over a narrow address window to provoke conflicts.
    for (int c = 0; c < 300; c++) begin
      for (int i = 0; i < NR; i++) begin
        if (!p_valid[i] && $urandom_range(0, 2) != 0) begin
          set_req(i, AW'($urandom_range(9'h080, 9'h083)), {$urandom, $urandom});
        end
      end
      step();
    end
    for (int c = 0; c < 20; c++) begin
      pend = 0;
      for (int i = 0; i < NR; i++) if (p_valid[i]) pend++;
      if (pend != 0) step();
    end
    pend = 0;
    for (int i = 0; i < NR; i++) if (p_valid[i]) pend++;
    check("drain_pending", 64'(pend), 64'd0);

    // Reset mid-INIT at cnt=100.
    areset = 1'b1;
    #1;
    check_reset_outputs("rst2");
    @(posedge aclk);
    #1;
    areset = 1'b0;
    repeat (50) @(posedge aclk);
    #1;
    check("mid_addr0", 64'(bus.wraddr[0 +: AW]), 64'd98);
    check("mid_addr1", 64'(bus.wraddr[AW +: AW]), 64'd99);
    #1;
    areset = 1'b1;
    #1;
    check_reset_outputs("rst_mid");
    #1;
    areset = 1'b0;
    init_phase();
    set_req(2, 9'h1FF, 64'h2222);
    step();

    // INIT_EN=0 instance: arbitration open straight out of reset.
    #1;
    check("ie0_done_rst", 64'(bus2.init_done), 64'd1);
    check("ie0_wren_rst", 64'(bus2.wren), 64'd0);
    areset2 = 1'b0;
    #1;
    check("ie0_ready", 64'(bus2.req_ready), 64'b0010);
    @(posedge aclk);
    #1;
    $display("ie0 beat: wren=%b addr0=%h", bus2.wren, bus2.wraddr[0 +: AW]);
    check("ie0_wren", 64'(bus2.wren), 64'd1);
    check("ie0_addr", 64'(bus2.wraddr[0 +: AW]), 64'h55);
    check("ie0_data", bus2.wrdata[0 +: DW], 64'hDEAD_BEEF_0000_0055);
    check("ie0_done", 64'(bus2.init_done), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/mem_wr_scheduler.md
Name: mem_wr_scheduler

Overview:
- Shares the NB_WRAGENT write ports of the multi-port RAM between NB_REQ write requesters.
- Grants up to NB_WRAGENT requests per cycle with round-robin fairness.
- Never issues two writes to the same address in the same cycle.
- After reset, optionally sequences a full-RAM initialisation over all write ports before opening arbitration.
- Sits upstream of the memory-map accounter and bram bank write side, and drives their wren/wraddr/wrdata buses directly.

Parameters:
ADDR_WIDTH, 9, address width in bits
RAM_DEPTH, 2**ADDR_WIDTH, number of RAM words (must be ≥ NB_WRAGENT)
DATA_WIDTH, 64, data width in bits
NB_REQ, 4, number of write requesters (≥2)
NB_WRAGENT, 2, number of RAM write ports (≥1, ≤ NB_REQ)
INIT_EN, 1, 1 = clear RAM after reset, 0 = arbitrate immediately
INIT_VALUE, 0, DATA_WIDTH-bit value written during initialisation

Ports:
aclk  in  1  clock
areset  in  1  asynchronous reset, active-high
req_valid  in  NB_REQ  per-requester write request
req_ready  out  NB_REQ  per-requester grant; transfer when valid & ready
req_addr  in  NB_REQ*ADDR_WIDTH  flattened request addresses, requester i at [i*ADDR_WIDTH +: ADDR_WIDTH]
req_data  in  NB_REQ*DATA_WIDTH  flattened request data
wren  out  NB_WRAGENT  RAM write enables
wraddr  out  NB_WRAGENT*ADDR_WIDTH  RAM write addresses, flattened
wrdata  out  NB_WRAGENT*DATA_WIDTH  RAM write data, flattened
init_done  out  1  high once initialisation is complete; stays high until reset

Behaviour:
- Reset (async assert, sync deassert use):
  - wren=0, wraddr=0, wrdata=0, req_ready=0.
  - rr_ptr=0, init counter=0.
  - State=INIT with init_done=0 if INIT_EN=1; otherwise state=RUN with init_done=1.
- Reset asserted mid-operation:
  - Outputs clear immediately.
  - Any in-flight registered write is dropped.
  - Initialisation restarts from address 0.
- FSM states: INIT, RUN.
- INIT:
  - req_ready=0 for all requesters.
  - Each cycle, port k writes INIT_VALUE at address cnt+k when cnt+k < RAM_DEPTH; otherwise wren[k]=0.
  - cnt advances by NB_WRAGENT each cycle.
  - When cnt+NB_WRAGENT ≥ RAM_DEPTH, the last batch is issued and state→RUN; init_done rises on the same edge.
  - INIT lasts ceil(RAM_DEPTH/NB_WRAGENT) cycles.
- RUN arbitration (combinational per cycle):
  - Scan requesters starting at rr_ptr, wrapping modulo NB_REQ.
  - Grant a valid requester if fewer than NB_WRAGENT are already granted this cycle and its req_addr differs from every address already granted this cycle.
  - An address-conflicting requester is skipped and keeps req_valid pending; it is not lost.
  - req_ready[i]=1 only for granted requesters.
  - req_ready is combinational from req_valid/req_addr and rr_ptr.
  - Requesters hold valid/addr/data stable until ready.
- Port mapping:
  - j-th granted requester in scan order → write port j.
  - Ports beyond the grant count get wren=0; their wraddr/wrdata hold previous values.
- Latency: grant in cycle N → wren/wraddr/wrdata registered, visible in cycle N+1. Fixed 1-cycle latency, no back-pressure from the RAM.
- rr_ptr update, at the end of a cycle with ≥1 grant: (index of last granted requester + 1) mod NB_REQ. Unchanged when there are no grants.
- Fairness: every continuously valid requester is granted within ceil(NB_REQ/NB_WRAGENT) grant cycles, given no persistent address conflict.
- Same-address requests from different requesters are serialised in round-robin order across cycles. The write order therefore defines the final RAM value.
- req_valid asserted during INIT is ignored, and is considered from the first RUN cycle.

Test Plan:
- Init sequence, defaults: release reset → wren=2'b11 for 256 cycles, addresses (0,1),(2,3)…(510,511), data 0. init_done=1 after cycle 256. No req_ready during INIT.
- All four requesters valid, distinct addresses 0x10–0x13, rr_ptr=0:
  - Cycle 1 grants req0→port0, req1→port1; cycle 2 grants req2, req3.
  - wren=11 on both following cycles; rr_ptr returns to 0.
- Address conflict: req0 and req1 both addr 0x40 (data A/B), req2 addr 0x41.
  - Cycle 1 grants req0 and req2.
  - Cycle 2 grants req1 alone, with wren=01, wraddr0=0x40, data B.
- Single requester: req3 valid alone for 3 cycles with rr_ptr=1 → req3 granted each cycle on port 0, wren=01, rr_ptr=0 after each grant.
- Reset mid-INIT at cnt=100 → outputs zero immediately; after release, INIT restarts at address 0 and completes 256 cycles later.
- INIT_EN=0: release reset with req1 valid → init_done=1 immediately, req_ready[1]=1 in the first cycle, write visible the next cycle.
